// File: rtl/hazard_control_unit.sv
// Hazard controller for the 5-stage MIPS core: load-use and unforwardable branch/jr
// stalls, taken-transfer flush, HALT drain sequencing and a saturating stall counter.
module hazard_control_unit #(
    parameter int NB_REG_ADDR  = 5,
    parameter int NB_CNT       = 16,
    parameter int DRAIN_CYCLES = 3
) (
    input  logic                   i_clock,
    input  logic                   i_reset,
    input  logic                   i_valid,
    input  logic [NB_REG_ADDR-1:0] i_rs,
    input  logic [NB_REG_ADDR-1:0] i_rt,
    input  logic                   i_use_rs,
    input  logic                   i_use_rt,
    input  logic                   i_branch_id,
    input  logic                   i_jump_rs_id,
    input  logic                   i_taken,
    input  logic                   i_halt_id,
    input  logic                   i_mem_read_ex,
    input  logic                   i_we_ex,
    input  logic [NB_REG_ADDR-1:0] i_rd_ex,
    input  logic                   i_mem_read_mem,
    input  logic [NB_REG_ADDR-1:0] i_rd_mem,
    output logic                   o_pc_we,
    output logic                   o_ifid_we,
    output logic                   o_ifid_flush,
    output logic                   o_idex_bubble,
    output logic                   o_halted,
    output logic [NB_CNT-1:0]      o_stall_count
);

    localparam int NB_DRAIN = $clog2(DRAIN_CYCLES + 1);
    localparam logic [NB_CNT-1:0]   CNT_ONE    = NB_CNT'(1);
    localparam logic [NB_CNT-1:0]   CNT_MAX    = '1;
    localparam logic [NB_DRAIN-1:0] DRAIN_ONE  = NB_DRAIN'(1);
    localparam logic [NB_DRAIN-1:0] DRAIN_LOAD = NB_DRAIN'(DRAIN_CYCLES - 1);

    typedef enum logic [1:0] {RUN, DRAIN, HALTED} state_t;

    state_t                state_q, state_d;
    logic [NB_DRAIN-1:0]   drain_q, drain_d;
    logic [NB_CNT-1:0]     cnt_q, cnt_d;

    logic m_ex_a, m_ex_b, m_mem_a, m_mem_b;
    logic load_use, ctrl_ex, ctrl_mem, stall;

    // Register 0 is hardwired, so a zero destination never creates a dependency
    assign m_ex_a   = i_use_rs & (i_rs == i_rd_ex)  & (i_rd_ex  != '0);
    assign m_ex_b   = i_use_rt & (i_rt == i_rd_ex)  & (i_rd_ex  != '0);
    assign m_mem_a  = i_use_rs & (i_rs == i_rd_mem) & (i_rd_mem != '0);
    assign m_mem_b  = i_use_rt & (i_rt == i_rd_mem) & (i_rd_mem != '0);

    assign load_use = i_mem_read_ex & (m_ex_a | m_ex_b);
    // ID-stage compare only sees MEM/WB forwarding, so any EX producer must wait
    assign ctrl_ex  = (i_branch_id & i_we_ex & (m_ex_a | m_ex_b)) |
                      (i_jump_rs_id & i_we_ex & m_ex_a);
    assign ctrl_mem = i_mem_read_mem & ((i_branch_id & (m_mem_a | m_mem_b)) |
                                        (i_jump_rs_id & m_mem_a));
    assign stall    = load_use | ctrl_ex | ctrl_mem;

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state_q <= RUN;
            drain_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            drain_q <= drain_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        drain_d       = drain_q;
        cnt_d         = cnt_q;
        o_pc_we       = 1'b0;
        o_ifid_we     = 1'b0;
        o_ifid_flush  = 1'b0;
        o_idex_bubble = 1'b0;
        o_halted      = (state_q == HALTED) & ~i_reset;
        if (!i_reset && i_valid) begin
            case (state_q)
                RUN: begin
                    if (stall) begin
                        o_idex_bubble = 1'b1;
                        if (cnt_q != CNT_MAX)
                            cnt_d = cnt_q + CNT_ONE;
                    end else if (i_halt_id) begin
                        o_idex_bubble = 1'b1;
                        drain_d       = DRAIN_LOAD;
                        state_d       = DRAIN;
                    end else begin
                        o_pc_we      = 1'b1;
                        o_ifid_we    = 1'b1;
                        o_ifid_flush = i_taken;
                    end
                end
                DRAIN: begin
                    o_idex_bubble = 1'b1;
                    if (drain_q == '0)
                        state_d = HALTED;
                    else
                        drain_d = drain_q - DRAIN_ONE;
                end
                HALTED: begin
                    o_idex_bubble = 1'b1;
                end
                default: begin
                    state_d = RUN;
                end
            endcase
        end
    end

    assign o_stall_count = i_reset ? '0 : cnt_q;

endmodule
